// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests under a credit limit,
// buffers returned words with their PCs and presents the buffer head to the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_stop,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] LAST_C  = PW'(BUF_DEPTH - 1);
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(BUF_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   buf_pc_q   [BUF_DEPTH];
    logic [31:0]   buf_inst_q [BUF_DEPTH];
    logic [31:0]   infl_pc_q  [BUF_DEPTH];
    logic [PW-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
    logic [PW-1:0] infl_rd_q, infl_rd_d, infl_wr_q, infl_wr_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;
    logic [CW-1:0] infl_cnt_q, infl_cnt_d;
    logic [CW-1:0] disc_cnt_q, disc_cnt_d;
    logic [CW+1:0] occupancy;
    logic          issue, rsp_drop, rsp_keep, rsp_any, consume;
    logic [31:0]   head_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    // Discarded (not yet returned) fetches still hold a credit, so they count toward occupancy.
    assign occupancy = {2'b00, buf_cnt_q} + {2'b00, infl_cnt_q} + {2'b00, disc_cnt_q};
    assign imem_req  = !rst && !redirect_valid && (occupancy < DEPTH_W);
    assign imem_addr = rst ? '0 : fetch_pc_q;
    assign issue     = imem_req && imem_gnt;

    assign rsp_drop  = imem_rvalid && (disc_cnt_q != '0);
    assign rsp_keep  = imem_rvalid && (disc_cnt_q == '0) && (infl_cnt_q != '0);
    assign rsp_any   = rsp_drop || rsp_keep;

    assign head_pc      = buf_pc_q[buf_rd_q];
    assign inst_valid_o = (buf_cnt_q != '0) && !rst && !redirect_valid;
    assign pc_o         = inst_valid_o ? head_pc : '0;
    assign pc4_o        = inst_valid_o ? head_pc + 32'd4 : '0;
    assign inst_o       = inst_valid_o ? buf_inst_q[buf_rd_q] : '0;
    assign consume      = inst_valid_o && !pipeline_stop;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        buf_rd_d   = buf_rd_q;
        buf_wr_d   = buf_wr_q;
        infl_rd_d  = infl_rd_q;
        infl_wr_d  = infl_wr_q;
        buf_cnt_d  = buf_cnt_q;
        infl_cnt_d = infl_cnt_q;
        disc_cnt_d = disc_cnt_q;
        if (redirect_valid) begin
            // Everything in flight becomes a discard; a response landing now is itself one of them.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            buf_rd_d   = '0;
            buf_wr_d   = '0;
            infl_rd_d  = '0;
            infl_wr_d  = '0;
            buf_cnt_d  = '0;
            infl_cnt_d = '0;
            disc_cnt_d = disc_cnt_q + infl_cnt_q - CW'(rsp_any);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                infl_wr_d  = ptr_inc(infl_wr_q);
            end
            if (rsp_keep) begin
                infl_rd_d = ptr_inc(infl_rd_q);
                buf_wr_d  = ptr_inc(buf_wr_q);
            end
            if (consume) begin
                buf_rd_d = ptr_inc(buf_rd_q);
            end
            disc_cnt_d = disc_cnt_q - CW'(rsp_drop);
            infl_cnt_d = infl_cnt_q + CW'(issue) - CW'(rsp_keep);
            buf_cnt_d  = buf_cnt_q + CW'(rsp_keep) - CW'(consume);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            buf_rd_q   <= '0;
            buf_wr_q   <= '0;
            infl_rd_q  <= '0;
            infl_wr_q  <= '0;
            buf_cnt_q  <= '0;
            infl_cnt_q <= '0;
            disc_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            buf_rd_q   <= buf_rd_d;
            buf_wr_q   <= buf_wr_d;
            infl_rd_q  <= infl_rd_d;
            infl_wr_q  <= infl_wr_d;
            buf_cnt_q  <= buf_cnt_d;
            infl_cnt_q <= infl_cnt_d;
            disc_cnt_q <= disc_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            infl_pc_q[infl_wr_q] <= fetch_pc_q;
        end
        if (rsp_keep && !redirect_valid) begin
            buf_pc_q[buf_wr_q]   <= infl_pc_q[infl_rd_q];
            buf_inst_q[buf_wr_q] <= imem_rdata;
        end
    end

    assert property (@(posedge clk) disable iff (rst) int'(occupancy) <= int'(BUF_DEPTH));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: hand-derived vector table for the directed corner cases, then random
// traffic against a queue-based reference model and an in-order instruction-memory model.
module tb_if_fetch_unit;
    localparam int DEPTH = 2;

    typedef struct {
        logic        rst, stop, redir;
        logic [31:0] rpc;
        logic        gnt, rv;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipeline_stop = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc_o, pc4_o, inst_o;
    logic        inst_valid_o;

    int n_cmp = 0;
    int n_err = 0;

    ent_t        m_buf[$];
    logic [31:0] m_infl[$];
    logic [31:0] memq[$];
    int          m_disc = 0;
    logic [31:0] m_pc = 32'h0;

    vec_t tbl[22];

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pipeline_stop(pipeline_stop),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_o(pc_o), .pc4_o(pc4_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic r, s, d, input logic [31:0] rpc, input logic g, v,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep);
        vec_t x;
        x.rst = r; x.stop = s; x.redir = d; x.rpc = rpc; x.gnt = g; x.rv = v;
        x.e_req = er; x.e_addr = ea; x.e_valid = ev; x.e_pc = ep;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input vec_t v, input bit use_tbl, input bit stray);
        logic        rv, m_req, m_valid, d_issue;
        logic [31:0] rd, d_addr, e_pc, e_inst;
        int          occ;
        @(negedge clk);
        rst = v.rst; pipeline_stop = v.stop; redirect_valid = v.redir;
        redirect_pc = v.rpc; imem_gnt = v.gnt;
        rv = 1'b0; rd = $urandom;
        if (v.rv && memq.size() > 0) begin
            rv = 1'b1; rd = inst_of(memq[0]);
        end else if (stray && !v.rst && memq.size() == 0 && m_infl.size() == 0 && m_disc == 0) begin
            rv = 1'b1;
        end
        imem_rvalid = rv; imem_rdata = rd;
        #1;
        occ     = m_buf.size() + m_infl.size() + m_disc;
        m_req   = !v.rst && !v.redir && (occ < DEPTH);
        m_valid = !v.rst && !v.redir && (m_buf.size() > 0);
        e_pc = '0; e_inst = '0;
        if (m_valid) begin
            e_pc = m_buf[0].pc; e_inst = m_buf[0].inst;
        end
        chk("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, v.rst ? 32'h0 : m_pc);
        chk("inst_valid", inst_valid_o, m_valid);
        chk("pc_o", pc_o, e_pc);
        chk("pc4_o", pc4_o, m_valid ? e_pc + 32'd4 : 32'h0);
        chk("inst_o", inst_o, e_inst);
        if (use_tbl) begin
            chk("tbl_req", imem_req, v.e_req);
            chk("tbl_addr", imem_addr, v.e_addr);
            chk("tbl_valid", inst_valid_o, v.e_valid);
            chk("tbl_pc", pc_o, v.e_valid ? v.e_pc : 32'h0);
            chk("tbl_pc4", pc4_o, v.e_valid ? v.e_pc + 32'd4 : 32'h0);
            chk("tbl_inst", inst_o, v.e_valid ? inst_of(v.e_pc) : 32'h0);
        end
        d_issue = imem_req && imem_gnt;
        d_addr  = imem_addr;
        @(posedge clk);
        if (v.rst) begin
            memq.delete();
        end else begin
            if (rv && memq.size() > 0) void'(memq.pop_front());
            if (d_issue) memq.push_back(d_addr);
        end
        if (v.rst) begin
            m_buf.delete(); m_infl.delete(); m_disc = 0; m_pc = 32'h0;
        end else if (v.redir) begin
            m_disc = m_disc + m_infl.size() - ((rv && (m_disc > 0 || m_infl.size() > 0)) ? 1 : 0);
            m_buf.delete(); m_infl.delete();
            m_pc = {v.rpc[31:2], 2'b00};
        end else begin
            if (m_valid && !v.stop) void'(m_buf.pop_front());
            if (rv) begin
                if (m_disc > 0) m_disc--;
                else if (m_infl.size() > 0) m_buf.push_back('{pc: m_infl.pop_front(), inst: rd});
            end
            if (m_req && v.gnt) begin
                m_infl.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        vec_t v;
        //            rst  stp  rdr  rpc            gnt  rv   req  addr           vld  pc
        tbl[0]  = mk(1'b1,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0);
        tbl[1]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h0,         1'b0,32'h0);
        tbl[2]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h4,         1'b0,32'h0);
        tbl[3]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h8,         1'b1,32'h0);
        tbl[4]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h8,         1'b1,32'h4);
        tbl[5]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'hC,         1'b0,32'h0);
        tbl[6]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h10,        1'b1,32'h8);
        tbl[7]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h10,        1'b1,32'hC);
        tbl[8]  = mk(1'b0,1'b0,1'b1,32'hFFFF_FFFC, 1'b1,1'b1,1'b0,32'h14,        1'b0,32'h0);
        tbl[9]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'hFFFF_FFFC, 1'b0,32'h0);
        tbl[10] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h0,         1'b0,32'h0);
        tbl[11] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h4,         1'b1,32'hFFFF_FFFC);
        tbl[12] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h4,         1'b1,32'h0);
        tbl[13] = mk(1'b0,1'b1,1'b1,32'h203,       1'b1,1'b0,1'b0,32'h8,         1'b0,32'h0);
        tbl[14] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h200,       1'b0,32'h0);
        tbl[15] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h204,       1'b0,32'h0);
        tbl[16] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h208,       1'b1,32'h200);
        tbl[17] = mk(1'b0,1'b1,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h208,       1'b1,32'h204);
        tbl[18] = mk(1'b0,1'b1,1'b1,32'h40,        1'b1,1'b1,1'b0,32'h20C,       1'b0,32'h0);
        tbl[19] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h40,        1'b0,32'h0);
        tbl[20] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h44,        1'b0,32'h0);
        tbl[21] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h48,        1'b1,32'h40);

        for (int i = 0; i < 22; i++) cycle(tbl[i], 1'b1, 1'b0);

        // Stall the consumer for 4 cycles mid-stream, then release.
        for (int i = 0; i < 10; i++) begin
            v = mk(1'b0, (i >= 2 && i < 6), 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            cycle(v, 1'b0, 1'b0);
        end
        // Grant withheld for 3 cycles so the buffer drains.
        for (int i = 0; i < 8; i++) begin
            v = mk(1'b0, 1'b0, 1'b0, 32'h0, !(i < 3), 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            cycle(v, 1'b0, 1'b0);
        end

        for (int i = 0; i < 3000; i++) begin
            v = mk(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 3),
                   ($urandom_range(0, 19) == 0),
                   ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : 32'($urandom),
                   ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                   1'b0, 32'h0, 1'b0, 32'h0);
            cycle(v, 1'b0, ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
